stream_sequencer: RTL and testbench

- Programs the DDR3 stream read master through its 3-bit CSR port and plays a table of up to NUM_DESC stream segments back to back, with optional looping.
- The host loads descriptors over an Avalon-MM slave.
- The block sits between the host CSR bus and the read master's slave port and is the only writer of that port.

---
 rtl/stream_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_stream_sequencer.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_sequencer.sv
// -----------------------------------------------------------------------------
// stream_sequencer
//
// Plays a table of up to NUM_DESC stream segments through the DDR3 stream read
// master, back to back and optionally looping. For every segment the block
// resets the read master, programs base/end/step/rate, starts it, then polls
// the done flag every POLL_GAP idle cycles until the segment completes. The
// host loads descriptors and controls the sequence over an Avalon-MM slave.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   avs_*           host CSR slave (5-bit word address, 32-bit data);
//                   avs_readdata is registered with 1-cycle latency
//   rm_*            read master CSR port (3-bit address, 32-bit data);
//                   rm_readdata is valid exactly 1 cycle after rm_read
//   busy            a sequence is active
//   seq_done        sticky, the last sequence ran to completion
//
// Host map (word addresses):
//   0x00 CTRL      W: bit0 start (pulse), bit1 loop (stored), bit2 abort (pulse)
//   0x01 STATUS    R: {30'b0, seq_done, busy}
//   0x02 DESC_CNT  RW [2:0], clamped to NUM_DESC when a sequence starts
//   0x03 CUR_IDX   R: descriptor currently being played
//   0x04 SEG_DONE  R: segments completed since the last start (wraps)
//   0x08+4*i+k     RW descriptor i, k = 0 base, 1 end, 2 step, 3 rate
//   anything else  reads 0xDEADBEEF, writes ignored
// -----------------------------------------------------------------------------
module stream_sequencer #(
   parameter int NUM_DESC = 4,   // descriptor table depth, power of 2, max 4
   parameter int POLL_GAP = 8    // idle cycles between done polls, >= 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  avs_addr,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic        avs_read,
   output logic [31:0] avs_readdata,
   output logic [2:0]  rm_addr,
   output logic        rm_write,
   output logic [31:0] rm_writedata,
   output logic        rm_read,
   input  logic [31:0] rm_readdata,
   output logic        busy,
   output logic        seq_done
);

   localparam int          IW       = (NUM_DESC > 1) ? $clog2(NUM_DESC) : 1;
   localparam int          GW       = $clog2(POLL_GAP + 1);
   localparam logic [2:0]  MAX_CNT  = 3'(NUM_DESC);
   localparam logic [31:0] UNMAPPED = 32'hDEAD_BEEF;

   // Read master CSR map
   localparam logic [2:0] RM_BASE  = 3'd0;
   localparam logic [2:0] RM_END   = 3'd1;
   localparam logic [2:0] RM_STEP  = 3'd2;
   localparam logic [2:0] RM_RATE  = 3'd3;
   localparam logic [2:0] RM_START = 3'd4;
   localparam logic [2:0] RM_DONE  = 3'd5;
   localparam logic [2:0] RM_RESET = 3'd6;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RM_RST,
      S_WR_BASE,
      S_WR_END,
      S_WR_STEP,
      S_WR_RATE,
      S_WR_START,
      S_GAP,
      S_POLL,
      S_POLL_WAIT,
      S_NEXT,
      S_FIN
   } state_t;

   state_t state_q, state_d;

   // Host-visible configuration
   logic [31:0] desc_q [NUM_DESC][4];
   logic        loop_q;
   logic [2:0]  desc_cnt_q;

   // Sequencer datapath
   logic [IW-1:0] idx_q;
   logic [2:0]    run_cnt_q;     // DESC_CNT as clamped at start
   logic [GW-1:0] gap_q;
   logic [31:0]   seg_done_q;

   // FSM strobes into the datapath
   logic run_start, empty_start, seg_inc, idx_adv, idx_wrap;
   logic seq_finish, seq_abort;

   // ---------------------------------------------------------------------------
   // Host decode
   // ---------------------------------------------------------------------------
   logic          ctrl_wr, start_cmd, abort_cmd;
   logic [2:0]    desc_slot;
   logic          desc_hit;
   logic [IW-1:0] desc_idx;
   logic [1:0]    desc_fld;
   logic [2:0]    cnt_clamped;
   logic [31:0]   rd_mux;

   assign ctrl_wr     = avs_write && (avs_addr == 5'h00);
   // A start carried in the same write as an abort is dropped.
   assign start_cmd   = ctrl_wr && avs_writedata[0] && !avs_writedata[2];
   assign abort_cmd   = ctrl_wr && avs_writedata[2];

   // Descriptor window starts at 0x08, four words per descriptor.
   assign desc_slot   = avs_addr[4:2] - 3'd2;
   assign desc_hit    = (avs_addr >= 5'h08) && (desc_slot < MAX_CNT);
   assign desc_idx    = desc_slot[IW-1:0];
   assign desc_fld    = avs_addr[1:0];

   assign cnt_clamped = (desc_cnt_q > MAX_CNT) ? MAX_CNT : desc_cnt_q;

   // Only the done bit of the read master status is meaningful.
   logic unused_rm_bits;
   assign unused_rm_bits = &{1'b0, rm_readdata[31:1]};

   always_comb begin
      rd_mux = UNMAPPED;
      case (avs_addr)
         5'h00:   rd_mux = {29'd0, 1'b0, loop_q, 1'b0};
         5'h01:   rd_mux = {30'd0, seq_done, busy};
         5'h02:   rd_mux = {29'd0, desc_cnt_q};
         5'h03:   rd_mux = 32'(idx_q);
         5'h04:   rd_mux = seg_done_q;
         default: if (desc_hit) rd_mux = desc_q[desc_idx][desc_fld];
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loop_q       <= 1'b0;
         desc_cnt_q   <= 3'd0;
         avs_readdata <= 32'd0;
         // NOTE: the descriptor table is cleared on reset so a start issued
         // after rst can never replay segments left over from before it.
         for (int i = 0; i < NUM_DESC; i++) begin
            for (int k = 0; k < 4; k++) begin
               desc_q[i][k] <= 32'd0;
            end
         end
      end else begin
         if (avs_write) begin
            if (avs_addr == 5'h00) loop_q     <= avs_writedata[1];
            if (avs_addr == 5'h02) desc_cnt_q <= avs_writedata[2:0];
            if (desc_hit)          desc_q[desc_idx][desc_fld] <= avs_writedata;
         end
         if (avs_read) avs_readdata <= rd_mux;
      end
   end

   // ---------------------------------------------------------------------------
   // Sequencer FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // ---------------------------------------------------------------------------
   // Sequencer FSM: next state and read master strobes. The rm_* outputs are
   // decoded straight from the state register, so they drop as soon as rst
   // forces the state back to IDLE.
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default here; any path that
      // skipped an assignment would otherwise infer a latch.
      state_d      = state_q;
      rm_addr      = 3'd0;
      rm_write     = 1'b0;
      rm_writedata = 32'd0;
      rm_read      = 1'b0;
      run_start    = 1'b0;
      empty_start  = 1'b0;
      seg_inc      = 1'b0;
      idx_adv      = 1'b0;
      idx_wrap     = 1'b0;
      seq_finish   = 1'b0;
      seq_abort    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_cmd) begin
               if (cnt_clamped != 3'd0) begin
                  run_start = 1'b1;
                  state_d   = S_RM_RST;
               end else begin
                  empty_start = 1'b1;
               end
            end
         end
         S_RM_RST: begin
            rm_write = 1'b1;
            rm_addr  = RM_RESET;
            state_d  = S_WR_BASE;
         end
         S_WR_BASE: begin
            rm_write     = 1'b1;
            rm_addr      = RM_BASE;
            rm_writedata = desc_q[idx_q][0];
            state_d      = S_WR_END;
         end
         S_WR_END: begin
            rm_write     = 1'b1;
            rm_addr      = RM_END;
            rm_writedata = desc_q[idx_q][1];
            state_d      = S_WR_STEP;
         end
         S_WR_STEP: begin
            rm_write     = 1'b1;
            rm_addr      = RM_STEP;
            rm_writedata = desc_q[idx_q][2];
            state_d      = S_WR_RATE;
         end
         S_WR_RATE: begin
            rm_write     = 1'b1;
            rm_addr      = RM_RATE;
            rm_writedata = desc_q[idx_q][3];
            state_d      = S_WR_START;
         end
         S_WR_START: begin
            rm_write     = 1'b1;
            rm_addr      = RM_START;
            rm_writedata = 32'd1;
            state_d      = S_GAP;
         end
         S_GAP: begin
            if (gap_q == '0) state_d = S_POLL;
         end
         S_POLL: begin
            rm_read = 1'b1;
            rm_addr = RM_DONE;
            state_d = S_POLL_WAIT;
         end
         S_POLL_WAIT: begin
            state_d = rm_readdata[0] ? S_NEXT : S_GAP;
         end
         S_NEXT: begin
            seg_inc = 1'b1;
            if ((3'(idx_q) + 3'd1) < run_cnt_q) begin
               idx_adv = 1'b1;
               state_d = S_RM_RST;
            end else if (loop_q) begin
               idx_wrap = 1'b1;
               state_d  = S_RM_RST;
            end else begin
               seq_finish = 1'b1;
               state_d    = S_FIN;
            end
         end
         S_FIN: begin
            rm_write = 1'b1;
            rm_addr  = RM_RESET;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides whatever the active state decided and takes the
      // cleanup path; the segment in flight is not counted.
      if (abort_cmd && (state_q != S_IDLE)) begin
         state_d    = S_FIN;
         seq_abort  = 1'b1;
         seg_inc    = 1'b0;
         idx_adv    = 1'b0;
         idx_wrap   = 1'b0;
         seq_finish = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Sequencer datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q      <= '0;
         run_cnt_q  <= 3'd0;
         gap_q      <= '0;
         seg_done_q <= 32'd0;
         busy       <= 1'b0;
         seq_done   <= 1'b0;
      end else begin
         // NOTE: all state here is updated with non-blocking assignments so
         // every register samples the pre-edge values of its neighbours.
         // The gap counter is preloaded everywhere outside GAP, so each GAP
         // visit lasts exactly POLL_GAP cycles.
         if (state_q != S_GAP)  gap_q <= GW'(POLL_GAP - 1);
         else if (gap_q != '0)  gap_q <= gap_q - GW'(1);

         if (run_start || empty_start) seg_done_q <= 32'd0;
         else if (seg_inc)             seg_done_q <= seg_done_q + 32'd1;

         if (run_start || idx_wrap) idx_q <= '0;
         else if (idx_adv)          idx_q <= idx_q + IW'(1);

         if (run_start) run_cnt_q <= cnt_clamped;

         if (run_start) begin
            busy     <= 1'b1;
            seq_done <= 1'b0;
         end else if (empty_start) begin
            seq_done <= 1'b1;
         end else if (seq_finish) begin
            busy     <= 1'b0;
            seq_done <= 1'b1;
         end else if (seq_abort) begin
            busy     <= 1'b0;
            seq_done <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stream_sequencer
//
// Scoreboard bench for stream_sequencer. Stimulus pushes the read master
// writes a sequence must produce (segment i visited in order i = s mod count,
// each as reset/base/end/step/rate/start, then a final reset) and the host
// read results it expects; a monitor pops and compares whenever the DUT shows
// rm_write, rm_read or host read data. A small read master model answers
// polls, reporting done on a chosen poll of each segment.
// -----------------------------------------------------------------------------
module tb_stream_sequencer;

   localparam int NUM_DESC = 4;
   localparam int POLL_GAP = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  avs_addr;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic        avs_read;
   logic [31:0] avs_readdata;
   logic [2:0]  rm_addr;
   logic        rm_write;
   logic [31:0] rm_writedata;
   logic        rm_read;
   logic [31:0] rm_readdata;
   logic        busy;
   logic        seq_done;

   stream_sequencer #(.NUM_DESC(NUM_DESC), .POLL_GAP(POLL_GAP)) dut (
      .clk           (clk),
      .rst           (rst),
      .avs_addr      (avs_addr),
      .avs_write     (avs_write),
      .avs_writedata (avs_writedata),
      .avs_read      (avs_read),
      .avs_readdata  (avs_readdata),
      .rm_addr       (rm_addr),
      .rm_write      (rm_write),
      .rm_writedata  (rm_writedata),
      .rm_read       (rm_read),
      .rm_readdata   (rm_readdata),
      .busy          (busy),
      .seq_done      (seq_done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model state
   // ---------------------------------------------------------------------------
   typedef struct {
      logic [2:0]  addr;
      logic [31:0] data;
      bit          care;
   } rm_wr_t;

   rm_wr_t      wr_q[$];
   logic [31:0] rd_q[$];
   int          polls_q[$];
   logic [31:0] shadow [NUM_DESC][4];

   bit          armed = 1'b0;
   int          polls_left = 0;
   int unsigned last_wr_cyc = 0;
   int unsigned next_poll_cyc = 0;
   logic [31:0] poll_resp = 32'd0;
   bit          rd_pending = 1'b0;

   task automatic push_wr(input logic [2:0] a, input logic [31:0] d, input bit care);
      rm_wr_t w;
      w.addr = a;
      w.data = d;
      w.care = care;
      wr_q.push_back(w);
   endtask

   task automatic push_seg(input int i);
      push_wr(3'd6, 32'd0, 1'b1);
      for (int k = 0; k < 4; k++) push_wr(3'(k), shadow[i][k], 1'b1);
      push_wr(3'd4, 32'd0, 1'b0);
   endtask

   // A run of nseg segments over a table of cnt entries, then cleanup reset.
   task automatic expect_run(input int cnt, input int nseg);
      for (int s = 0; s < nseg; s++) push_seg(s % cnt);
      push_wr(3'd6, 32'd0, 1'b0);
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: scoreboard for rm traffic, host reads and poll timing
   // ---------------------------------------------------------------------------
   initial forever begin
      logic [31:0] r;
      rm_wr_t      w;
      @(negedge clk);
      if (rst) begin
         armed      = 1'b0;
         rd_pending = 1'b0;
         continue;
      end
      if (rd_pending) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL host read: got 0x%08h with nothing expected", avs_readdata);
         end else begin
            check("host read", avs_readdata, rd_q.pop_front());
         end
      end
      rd_pending = avs_read;

      check("rm strobes exclusive", 32'(rm_write & rm_read), 32'd0);

      if (rm_write) begin
         if (wr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rm write: got addr %0d data 0x%08h, expected no write", rm_addr, rm_writedata);
         end else begin
            w = wr_q.pop_front();
            check("rm write addr", 32'(rm_addr), 32'(w.addr));
            if (w.care) check("rm write data", rm_writedata, w.data);
            if (w.addr != 3'd6) check("rm burst spacing", cyc, last_wr_cyc + 1);
         end
         last_wr_cyc = cyc;
         if (rm_addr == 3'd4) begin
            armed         = 1'b1;
            polls_left    = (polls_q.size() != 0) ? polls_q.pop_front() : 1;
            next_poll_cyc = cyc + POLL_GAP + 1;
         end
         if (rm_addr == 3'd6) armed = 1'b0;
      end

      if (rm_read) begin
         check("poll addr", 32'(rm_addr), 32'd5);
         if (!armed) begin
            checks++;
            errors++;
            $display("FAIL poll: got rm_read at cycle %0d, expected none", cyc);
         end else begin
            check("poll timing", cyc, next_poll_cyc);
            next_poll_cyc = cyc + POLL_GAP + 2;
            polls_left--;
            r = $urandom;
            poll_resp = {r[31:1], (polls_left <= 0)};
         end
      end
   end

   // Read master response: valid in the cycle after rm_read, noise otherwise.
   initial begin
      rm_readdata = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         rm_readdata = poll_resp;
         poll_resp   = $urandom;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected bench to end");
      $fatal(1);
   end

   // ---------------------------------------------------------------------------
   // Host bus tasks
   // ---------------------------------------------------------------------------
   task automatic host_write(input logic [4:0] a, input logic [31:0] d);
      avs_addr      = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      @(posedge clk);
      #1;
      avs_write     = 1'b0;
   endtask

   task automatic host_read(input logic [4:0] a, input logic [31:0] exp);
      avs_addr = a;
      avs_read = 1'b1;
      rd_q.push_back(exp);
      @(posedge clk);
      #1;
      avs_read = 1'b0;
   endtask

   task automatic set_desc(input int i, input logic [31:0] b, input logic [31:0] e,
                           input logic [31:0] s, input logic [31:0] r);
      logic [31:0] v [4];
      v = '{b, e, s, r};
      for (int k = 0; k < 4; k++) begin
         shadow[i][k] = v[k];
         host_write(5'(8 + 4 * i + k), v[k]);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (busy && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, 32'(busy), 32'd0);
      idle(3);
   endtask

   task automatic wait_wr(input logic [2:0] a, input int budget);
      int n = 0;
      bit seen = 1'b0;
      while (!seen && n < budget) begin
         @(negedge clk);
         seen = rm_write && (rm_addr == a);
         n++;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL wait rm write: got none, expected addr %0d", a);
      end
      @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      rst = 1'b1;
      avs_addr = '0;
      avs_write = 1'b0;
      avs_writedata = '0;
      avs_read = 1'b0;
      idle(3);
      check("reset busy", 32'(busy), 32'd0);
      check("reset seq_done", 32'(seq_done), 32'd0);
      check("reset rm_write", 32'(rm_write), 32'd0);
      check("reset rm_read", 32'(rm_read), 32'd0);
      check("reset readdata", avs_readdata, 32'd0);
      rst = 1'b0;
      idle(1);
      host_read(5'h01, 32'd0);
      host_read(5'h02, 32'd0);
      host_read(5'h08, 32'd0);
      host_read(5'h04, 32'd0);
      host_read(5'h05, 32'hDEAD_BEEF);
      host_read(5'h1f, 32'hDEAD_BEEF);

      // Single segment, done on the third poll.
      set_desc(0, 32'h100, 32'h140, 32'd1, 32'd4);
      host_write(5'h02, 32'd1);
      polls_q.push_back(3);
      expect_run(1, 1);
      host_write(5'h00, 32'h1);
      host_read(5'h01, 32'h1);
      wait_idle("t1 finish", 200);
      check("t1 seq_done", 32'(seq_done), 32'd1);
      host_read(5'h04, 32'd1);
      host_read(5'h01, 32'h2);
      idle(2);
      check("t1 drained", wr_q.size(), 0);

      // Three segments in index order, CUR_IDX tracked.
      for (int i = 0; i < 3; i++) set_desc(i, $urandom, $urandom, $urandom, $urandom);
      host_write(5'h02, 32'd3);
      for (int i = 0; i < 3; i++) polls_q.push_back(int'($urandom_range(1, 3)));
      expect_run(3, 3);
      host_write(5'h00, 32'h1);
      for (int s = 0; s < 3; s++) begin
         wait_wr(3'd4, 200);
         host_read(5'h03, 32'(s));
      end
      wait_idle("t2 finish", 300);
      host_read(5'h04, 32'd3);
      idle(2);
      check("t2 drained", wr_q.size(), 0);

      // Looping over two entries, loop dropped during the sixth segment.
      for (int i = 0; i < 2; i++) set_desc(i, $urandom, $urandom, $urandom, $urandom);
      host_write(5'h02, 32'd2);
      for (int i = 0; i < 6; i++) polls_q.push_back(int'($urandom_range(1, 2)));
      expect_run(2, 6);
      host_write(5'h00, 32'h3);
      for (int s = 0; s < 6; s++) wait_wr(3'd4, 200);
      host_write(5'h00, 32'h0);
      wait_idle("t3 finish", 300);
      check("t3 seq_done", 32'(seq_done), 32'd1);
      host_read(5'h04, 32'd6);
      idle(2);
      check("t3 drained", wr_q.size(), 0);

      // Abort in GAP of segment 0 (start bit in same write is ignored).
      set_desc(0, $urandom, $urandom, $urandom, $urandom);
      host_write(5'h02, 32'd1);
      polls_q.push_back(50);
      push_seg(0);
      push_wr(3'd6, 32'd0, 1'b0);
      host_write(5'h00, 32'h1);
      wait_wr(3'd4, 50);
      idle(2);
      host_write(5'h00, 32'h5);
      check("abort rm_write", 32'(rm_write), 32'd1);
      check("abort rm_addr", 32'(rm_addr), 32'd6);
      check("abort busy", 32'(busy), 32'd0);
      check("abort seq_done", 32'(seq_done), 32'd0);
      idle(30);
      check("abort drained", wr_q.size(), 0);
      host_write(5'h00, 32'h5);
      idle(20);
      check("start+abort idle busy", 32'(busy), 32'd0);
      check("start+abort idle seq_done", 32'(seq_done), 32'd0);

      // Empty table, then clamped oversize count with a start while busy.
      host_write(5'h02, 32'd0);
      host_write(5'h00, 32'h1);
      check("empty start seq_done", 32'(seq_done), 32'd1);
      check("empty start busy", 32'(busy), 32'd0);
      idle(10);
      for (int i = 0; i < 4; i++) set_desc(i, $urandom, $urandom, $urandom, $urandom);
      host_write(5'h02, 32'd7);
      for (int i = 0; i < 4; i++) polls_q.push_back(int'($urandom_range(1, 3)));
      expect_run(4, 4);
      host_write(5'h00, 32'h1);
      wait_wr(3'd4, 50);
      host_write(5'h00, 32'h1);
      wait_idle("t5 finish", 400);
      host_read(5'h04, 32'd4);
      idle(2);
      check("t5 drained", wr_q.size(), 0);

      // rst in the middle of a poll, then replay from idx 0.
      set_desc(0, $urandom, $urandom, $urandom, $urandom);
      host_write(5'h02, 32'd1);
      polls_q.push_back(50);
      push_seg(0);
      host_write(5'h00, 32'h1);
      begin
         int n = 0;
         bit seen = 1'b0;
         while (!seen && n < 100) begin
            @(negedge clk);
            seen = rm_read;
            n++;
         end
         if (!seen) begin
            checks++;
            errors++;
            $display("FAIL wait poll: got no rm_read, expected a poll");
         end
      end
      #2;
      rst = 1'b1;
      #1;
      check("rst rm_read", 32'(rm_read), 32'd0);
      check("rst rm_write", 32'(rm_write), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst readdata", avs_readdata, 32'd0);
      check("rst drained", wr_q.size(), 0);
      wr_q.delete();
      polls_q.delete();
      rd_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);
      host_read(5'h08, 32'd0);
      host_read(5'h02, 32'd0);
      for (int i = 0; i < 2; i++) set_desc(i, $urandom, $urandom, $urandom, $urandom);
      host_write(5'h02, 32'd2);
      polls_q.push_back(2);
      polls_q.push_back(1);
      expect_run(2, 2);
      host_write(5'h00, 32'h1);
      wait_idle("t6 finish", 300);
      host_read(5'h04, 32'd2);
      idle(2);
      check("t6 drained", wr_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
